// File: rtl/mem_pkg.sv
// Shared types and constants for the halfword memory responder.
package mem_pkg;

   localparam int unsigned MEM_DEPTH_DEFAULT = 2**12;

   // Byte lanes of a halfword: lane 0 is the even byte (bits 15:8).
   localparam int unsigned LANE_HI = 0;
   localparam int unsigned LANE_LO = 1;
   localparam int unsigned LANES   = 2;

   typedef enum logic {
      S_CLEAR,
      S_RUN
   } state_t;

endpackage

// File: rtl/spram_bytewe.sv
// Single-port halfword RAM with per-byte write enables and a registered read-first output.
module spram_bytewe
   import mem_pkg::*;
#(
   parameter int unsigned DEPTH = MEM_DEPTH_DEFAULT,
   parameter int unsigned IW    = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [IW-1:0]        addr,
   input  logic [0:LANES-1]     we,
   input  logic [0:1][7:0]      wdata,
   input  logic                 re,
   output logic [0:1][7:0]      rdata
);

   logic [0:1][7:0] mem [DEPTH];

   // Array write: contents are never reset here, only overwritten.
   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (we[k]) begin
            mem[addr][k] <= wdata[k];
         end
      end
   end

   // Read-first output register; holds when no read is issued.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// CPU-facing halfword memory with post-reset clear sequencer and a valid/ready loader port.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned MEM_DEPTH      = MEM_DEPTH_DEFAULT,
   parameter bit          CLEAR_ON_RESET = 1'b1,
   localparam int unsigned ADDR_WIDTH    = $clog2(MEM_DEPTH * 2)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] i_mem_addr,
   input  logic [0:1][7:0]       i_mem_di,
   input  logic                  i_mem_en,
   input  logic                  i_mem_rd_en,
   input  logic [0:1]            i_mem_wr_en,
   output logic [0:1][7:0]       o_mem_do,
   input  logic                  i_ld_valid,
   output logic                  o_ld_ready,
   input  logic [ADDR_WIDTH-2:0] i_ld_addr,
   input  logic [15:0]           i_ld_data,
   output logic                  o_busy
);

   localparam int unsigned IW = ADDR_WIDTH - 1;
   localparam logic [IW-1:0] CNT_LAST = IW'(MEM_DEPTH - 1);

   state_t          state;
   logic [IW-1:0]   cnt;
   logic            busy;

   logic [IW-1:0]   ram_addr;
   logic [0:1]      ram_we;
   logic [0:1][7:0] ram_wdata;
   logic            ram_re;
   logic            run;

   // Byte address bit 0 is ignored: all accesses are halfword aligned.
   logic unused_addr0;
   assign unused_addr0 = i_mem_addr[0];

   // Requests are ignored while rst is high so nothing lands in the array during reset.
   assign run        = (state == S_RUN) && !rst;
   assign o_ld_ready = run && !i_mem_en;
   assign o_busy     = busy;

   // Clear sequencer: one word per cycle, then hand over to the CPU.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR_ON_RESET ? S_CLEAR : S_RUN;
         cnt   <= '0;
         busy  <= CLEAR_ON_RESET;
      end else begin
         unique case (state)
            S_CLEAR: begin
               cnt <= cnt + 1'b1;
               if (cnt == CNT_LAST) begin
                  state <= S_RUN;
                  busy  <= 1'b0;
               end
            end
            S_RUN: begin
               state <= S_RUN;
            end
            default: begin
               state <= S_RUN;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // Single write port: clear, then CPU, then loader, in priority order.
   always_comb begin
      ram_addr  = i_ld_addr;
      ram_we    = 2'b00;
      ram_wdata = i_ld_data;
      ram_re    = 1'b0;
      if (!rst && state == S_CLEAR) begin
         ram_addr  = cnt;
         ram_we    = 2'b11;
         ram_wdata = '0;
      end else if (run && i_mem_en) begin
         ram_addr  = i_mem_addr[ADDR_WIDTH-1:1];
         ram_we    = i_mem_wr_en;
         ram_wdata = i_mem_di;
         ram_re    = i_mem_rd_en;
      end else if (o_ld_ready && i_ld_valid) begin
         ram_addr             = i_ld_addr;
         ram_we               = 2'b11;
         ram_wdata[LANE_HI]   = i_ld_data[15:8];
         ram_wdata[LANE_LO]   = i_ld_data[7:0];
      end
   end

   spram_bytewe #(
      .DEPTH (MEM_DEPTH),
      .IW    (IW)
   ) u_ram (
      .clk   (clk),
      .rst   (rst),
      .addr  (ram_addr),
      .we    (ram_we),
      .wdata (ram_wdata),
      .re    (ram_re),
      .rdata (o_mem_do)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with a 16-word array and clear-on-reset enabled.
module tb_mem_responder;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 5;

   logic            clk = 1'b0;
   logic            rst;
   logic [AW-1:0]   i_mem_addr;
   logic [0:1][7:0] i_mem_di;
   logic            i_mem_en;
   logic            i_mem_rd_en;
   logic [0:1]      i_mem_wr_en;
   logic [0:1][7:0] o_mem_do;
   logic            i_ld_valid;
   logic            o_ld_ready;
   logic [AW-2:0]   i_ld_addr;
   logic [15:0]     i_ld_data;
   logic            o_busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic        en;
      logic        rd;
      logic [1:0]  wr;
      logic [4:0]  addr;
      logic [15:0] di;
      logic        lv;
      logic [3:0]  la;
      logic [15:0] ld;
      logic        exp_rdy;
      logic [15:0] exp_do;
   } vec_t;

   vec_t vecs [13];

   mem_responder #(
      .MEM_DEPTH      (DEPTH),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_mem_addr  (i_mem_addr),
      .i_mem_di    (i_mem_di),
      .i_mem_en    (i_mem_en),
      .i_mem_rd_en (i_mem_rd_en),
      .i_mem_wr_en (i_mem_wr_en),
      .o_mem_do    (o_mem_do),
      .i_ld_valid  (i_ld_valid),
      .o_ld_ready  (o_ld_ready),
      .i_ld_addr   (i_ld_addr),
      .i_ld_data   (i_ld_data),
      .o_busy      (o_busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      i_mem_addr  = '0;
      i_mem_di    = '0;
      i_mem_en    = 1'b0;
      i_mem_rd_en = 1'b0;
      i_mem_wr_en = 2'b00;
      i_ld_valid  = 1'b0;
      i_ld_addr   = '0;
      i_ld_data   = '0;
   endtask

   // Counts edges until o_busy drops, bounded so a stuck sequencer still reaches the summary.
   task automatic count_busy(output int n);
      n = 0;
      while (o_busy === 1'b1 && n < 100) begin
         step();
         n++;
      end
   endtask

   initial begin
      int n;
      // en rd wr addr di lv la ld exp_rdy exp_do
      vecs[0]  = '{1'b0, 1'b0, 2'b00, 5'd0,  16'h0000, 1'b1, 4'd3, 16'hBEEF, 1'b1, 16'h0000};
      vecs[1]  = '{1'b1, 1'b1, 2'b00, 5'd6,  16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hBEEF};
      vecs[2]  = '{1'b1, 1'b0, 2'b01, 5'd6,  16'h1234, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hBEEF};
      vecs[3]  = '{1'b1, 1'b1, 2'b00, 5'd6,  16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hBE34};
      vecs[4]  = '{1'b1, 1'b1, 2'b11, 5'd6,  16'h5555, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hBE34};
      vecs[5]  = '{1'b1, 1'b1, 2'b00, 5'd6,  16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'h5555};
      vecs[6]  = '{1'b1, 1'b1, 2'b00, 5'd6,  16'h0000, 1'b1, 4'd5, 16'hA1B2, 1'b0, 16'h5555};
      vecs[7]  = '{1'b0, 1'b0, 2'b00, 5'd6,  16'h0000, 1'b1, 4'd5, 16'hA1B2, 1'b1, 16'h5555};
      vecs[8]  = '{1'b1, 1'b1, 2'b00, 5'd10, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hA1B2};
      vecs[9]  = '{1'b0, 1'b0, 2'b11, 5'd10, 16'hFFFF, 1'b0, 4'd0, 16'h0000, 1'b1, 16'hA1B2};
      vecs[10] = '{1'b1, 1'b1, 2'b00, 5'd11, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hA1B2};
      vecs[11] = '{1'b1, 1'b0, 2'b10, 5'd0,  16'hAABB, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hA1B2};
      vecs[12] = '{1'b1, 1'b1, 2'b00, 5'd0,  16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 16'hAA00};

      idle_inputs();
      rst = 1'b1;
      step();
      step();
      chk("reset_busy", {15'd0, o_busy}, 16'h0001);
      chk("reset_do", o_mem_do, 16'h0000);
      chk("reset_ready", {15'd0, o_ld_ready}, 16'h0000);

      rst = 1'b0;
      count_busy(n);
      chk("clear_cycles", 16'(n), 16'd16);

      // Every word reads back zero after the clear.
      for (int w = 0; w < DEPTH; w++) begin
         i_mem_en    = 1'b1;
         i_mem_rd_en = 1'b1;
         i_mem_addr  = 5'(w * 2);
         step();
         chk($sformatf("cleared_word%0d", w), o_mem_do, 16'h0000);
      end

      for (int i = 0; i < 13; i++) begin
         i_mem_en    = vecs[i].en;
         i_mem_rd_en = vecs[i].rd;
         i_mem_wr_en = vecs[i].wr;
         i_mem_addr  = vecs[i].addr;
         i_mem_di    = vecs[i].di;
         i_ld_valid  = vecs[i].lv;
         i_ld_addr   = vecs[i].la;
         i_ld_data   = vecs[i].ld;
         #1;
         chk($sformatf("vec%0d_ready", i), {15'd0, o_ld_ready}, {15'd0, vecs[i].exp_rdy});
         step();
         chk($sformatf("vec%0d_do", i), o_mem_do, vecs[i].exp_do);
      end
      idle_inputs();

      // Reset partway through a clear restarts it from word 0.
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("midclear_busy", {15'd0, o_busy}, 16'h0001);
      rst = 1'b1;
      step();
      rst = 1'b0;
      // CPU and loader hammer word 1 for the whole clear; none of it may stick.
      i_mem_en    = 1'b1;
      i_mem_rd_en = 1'b1;
      i_mem_wr_en = 2'b11;
      i_mem_addr  = 5'd2;
      i_mem_di    = 16'h1111;
      i_ld_valid  = 1'b1;
      i_ld_addr   = 4'd1;
      i_ld_data   = 16'h2222;
      #1;
      chk("clear_ready_low", {15'd0, o_ld_ready}, 16'h0000);
      count_busy(n);
      idle_inputs();
      chk("restart_cycles", 16'(n), 16'd16);
      chk("clear_do_hold", o_mem_do, 16'h0000);

      i_mem_en    = 1'b1;
      i_mem_rd_en = 1'b1;
      i_mem_addr  = 5'd2;
      step();
      chk("clear_ignores_writes", o_mem_do, 16'h0000);
      i_mem_addr  = 5'd6;
      step();
      chk("reclear_word3", o_mem_do, 16'h0000);
      idle_inputs();
      #1;
      chk("run_ready_high", {15'd0, o_ld_ready}, 16'h0001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
